cc_branch_sequencer: RTL and testbench

Multi-cycle sequencer for the SLC-3 condition-code path. It owns the NZP condition-code register and decides when it loads: on instructions that write a register, it captures N/Z/P from the datapath bus once the result is valid. On BR, it evaluates BEN against the stored NZP and reports whether the branch is taken. It sits between the ISDU and the datapath, and is started once per decoded instruction by a Start/Done handshake.

---
 rtl/cc_branch_sequencer_if.sv | 25 ++
 rtl/cc_branch_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cc_branch_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cc_branch_sequencer_if.sv
// Handshake and datapath-bus signals between the ISDU/datapath (master)
// and the condition-code/branch sequencer (slave).
interface cc_branch_sequencer_if;
  logic        Start;
  logic [15:0] IR;
  logic [15:0] Bus;
  logic        BusValid;
  logic        Busy;
  logic        Done;
  logic        LD_CC;
  logic [2:0]  NZP;
  logic        BEN;
  logic        Take_Branch;
  logic        Timeout;

  modport master (
    output Start, IR, Bus, BusValid,
    input  Busy, Done, LD_CC, NZP, BEN, Take_Branch, Timeout
  );

  modport slave (
    input  Start, IR, Bus, BusValid,
    output Busy, Done, LD_CC, NZP, BEN, Take_Branch, Timeout
  );
endinterface

// File: rtl/cc_branch_sequencer.sv
// SLC-3 condition-code sequencer: owns NZP, loads it from the result bus on
// CC-writing instructions and evaluates BEN for BR, once per Start/Done.
module cc_branch_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  Clk,
  input  logic                  Reset,
  cc_branch_sequencer_if.slave  seq_if
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT_RESULT,
    S_BRANCH,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [15:0]      ir_q;
  logic [15:0]      ir_d;
  logic [2:0]       nzp_q;
  logic [2:0]       nzp_d;
  logic             ben_q;
  logic             ben_d;
  logic             timeout_q;
  logic             timeout_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [3:0]       opcode;
  logic             cc_op;
  logic             br_op;
  logic [2:0]       bus_nzp;
  logic             busy;
  logic             done;
  logic             ld_cc;
  logic             take_branch;
  logic             unused_ir;

  assign opcode    = ir_q[15:12];
  assign br_op     = (opcode == OP_BR);
  assign unused_ir = ^ir_q[8:0];

  always_comb begin
    cc_op = 1'b0;
    case (opcode)
      OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR, OP_LDI: cc_op = 1'b1;
      default:                                        cc_op = 1'b0;
    endcase
  end

  // Exactly one of N/Z/P is produced for any bus value.
  always_comb begin
    bus_nzp = 3'b001;
    if (seq_if.Bus[15]) begin
      bus_nzp = 3'b100;
    end else if (seq_if.Bus == 16'h0000) begin
      bus_nzp = 3'b010;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      ir_q      <= '0;
      nzp_q     <= '0;
      ben_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state     <= state_d;
      ir_q      <= ir_d;
      nzp_q     <= nzp_d;
      ben_q     <= ben_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    ir_d        = ir_q;
    nzp_d       = nzp_q;
    ben_d       = ben_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    busy        = 1'b1;
    done        = 1'b0;
    ld_cc       = 1'b0;
    take_branch = 1'b0;

    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (seq_if.Start) begin
          ir_d      = seq_if.IR;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_DECODE;
        end
      end

      S_DECODE: begin
        if (cc_op) begin
          state_d = S_WAIT_RESULT;
        end else if (br_op) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_DONE;
        end
      end

      // A valid result on the final wait cycle still wins over the timeout.
      S_WAIT_RESULT: begin
        if (seq_if.BusValid) begin
          ld_cc   = 1'b1;
          nzp_d   = bus_nzp;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_BRANCH: begin
        ben_d   = |(ir_q[11:9] & nzp_q);
        state_d = S_DONE;
      end

      S_DONE: begin
        done        = 1'b1;
        take_branch = br_op & ben_q;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign seq_if.Busy        = busy;
  assign seq_if.Done        = done;
  assign seq_if.LD_CC       = ld_cc;
  assign seq_if.NZP         = nzp_q;
  assign seq_if.BEN         = ben_q;
  assign seq_if.Take_Branch = take_branch;
  assign seq_if.Timeout     = timeout_q;

endmodule

// File: tb/tb_cc_branch_sequencer.sv
// Scoreboard bench for cc_branch_sequencer: a transaction-level model predicts
// each instruction's completion, and a monitor checks it when Done appears.
module tb_cc_branch_sequencer;

  localparam int TO = 15;

  typedef struct {
    logic [15:0] ir;
    int          t0;
    int          lat;
    logic [2:0]  nzp;
    logic        ben;
    logic        take;
    logic        tmo;
    int          ldcc;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  int         cyc = 0;
  int         n_compared = 0;
  int         n_mismatched = 0;
  int         ldcc_seen = 0;
  exp_t       sb[$];
  logic [2:0] m_nzp = 3'b000;
  logic       m_ben = 1'b0;

  cc_branch_sequencer_if sif();

  cc_branch_sequencer #(.TIMEOUT(TO)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .seq_if (sif)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15]) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  function automatic bit writes_cc(input logic [3:0] op);
    return (op == 4'h1) || (op == 4'h5) || (op == 4'h9) ||
           (op == 4'h2) || (op == 4'h6) || (op == 4'hA);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sif.Busy !== 1'b0 && n < 64) begin
      tick();
      n++;
    end
    check_output(name, 32'(sif.Busy), 32'd0);
  endtask

  // k = cycles BusValid is held low after WAIT_RESULT is entered.
  task automatic apply_stimulus(input logic [15:0] ir, input logic [15:0] bus_val,
                                input int k, input bit noise);
    exp_t e;
    int   valid_cyc;
    wait_idle("idle_before_start");
    e.ir = ir; e.t0 = cyc; e.take = 1'b0; e.tmo = 1'b0; e.ldcc = 0;
    valid_cyc = -1;
    if (ir[15:12] == 4'h0) begin
      m_ben  = |(ir[11:9] & m_nzp);
      e.take = m_ben;
      e.lat  = 3;
    end else if (writes_cc(ir[15:12])) begin
      valid_cyc = 2 + k;
      if (k <= TO - 1) begin
        m_nzp  = nzp_of(bus_val);
        e.ldcc = 1;
        e.lat  = 3 + k;
      end else begin
        e.tmo = 1'b1;
        e.lat = 2 + TO;
      end
    end else begin
      e.lat = 2;
    end
    e.nzp = m_nzp;
    e.ben = m_ben;
    sb.push_back(e);

    sif.Start    = 1'b1;
    sif.IR       = ir;
    sif.BusValid = noise;
    sif.Bus      = noise ? 16'h0001 : 16'($urandom);
    for (int c = 1; c <= e.lat; c++) begin
      tick();
      sif.Start = 1'b0;
      sif.IR    = 16'($urandom);
      if (!noise) begin
        sif.BusValid = (c == valid_cyc);
        sif.Bus      = (c == valid_cyc) ? bus_val : 16'($urandom);
      end
    end
    tick();
    sif.BusValid = 1'b0;
    wait_idle("idle_after_done");
    check_output("done_seen", 32'(sb.size()), 32'd0);
  endtask

  task automatic hold_start_through_done();
    exp_t e;
    wait_idle("idle_before_hold");
    e.ir = 16'hE005; e.t0 = cyc; e.lat = 2; e.nzp = m_nzp; e.ben = m_ben;
    e.take = 1'b0; e.tmo = 1'b0; e.ldcc = 0;
    sb.push_back(e);
    e.t0 = cyc + 3;
    sb.push_back(e);
    sif.Start = 1'b1;
    sif.IR    = 16'hE005;
    tick();
    tick();
    tick();
    check_output("hold_idle_gap_busy", 32'(sif.Busy), 32'd0);
    tick();
    check_output("hold_reaccept_busy", 32'(sif.Busy), 32'd1);
    sif.Start = 1'b0;
    tick();
    tick();
    wait_idle("idle_after_hold");
    check_output("hold_done_count", 32'(sb.size()), 32'd0);
  endtask

  task automatic reset_mid_wait();
    apply_stimulus(16'h1005, 16'h0005, 0, 1'b0);
    apply_stimulus(16'h0201, 16'h0000, 0, 1'b0);
    wait_idle("idle_before_reset_test");
    sif.Start    = 1'b1;
    sif.IR       = 16'h6281;
    sif.BusValid = 1'b0;
    tick();
    sif.Start = 1'b0;
    tick();
    tick();
    check_output("wait_state_busy", 32'(sif.Busy), 32'd1);
    Reset        = 1'b1;
    sif.BusValid = 1'b1;
    sif.Bus      = 16'h8000;
    tick();
    Reset = 1'b0;
    m_nzp = 3'b000;
    m_ben = 1'b0;
    check_output("rst_mid_busy", 32'(sif.Busy), 32'd0);
    check_output("rst_mid_done", 32'(sif.Done), 32'd0);
    check_output("rst_mid_ldcc", 32'(sif.LD_CC), 32'd0);
    check_output("rst_mid_nzp", 32'(sif.NZP), 32'd0);
    check_output("rst_mid_ben", 32'(sif.BEN), 32'd0);
    check_output("rst_mid_timeout", 32'(sif.Timeout), 32'd0);
    check_output("rst_mid_take", 32'(sif.Take_Branch), 32'd0);
    sif.BusValid = 1'b0;
    repeat (20) tick();
    check_output("rst_mid_stays_idle", 32'(sif.Busy), 32'd0);
  endtask

  // Monitor: every Done must match the oldest outstanding prediction.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      ldcc_seen = 0;
    end else begin
      if (sif.LD_CC === 1'b1) ldcc_seen++;
      if (sif.Done === 1'b1) begin
        if (sb.size() == 0) begin
          check_output("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_output("latency", 32'(cyc - e.t0), 32'(e.lat));
          check_output("busy_with_done", 32'(sif.Busy), 32'd1);
          check_output("take_branch", 32'(sif.Take_Branch), 32'(e.take));
          check_output("nzp", 32'(sif.NZP), 32'(e.nzp));
          check_output("ben", 32'(sif.BEN), 32'(e.ben));
          check_output("timeout", 32'(sif.Timeout), 32'(e.tmo));
          check_output("ld_cc_pulses", 32'(ldcc_seen), 32'(e.ldcc));
        end
        ldcc_seen = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ir;
    logic [15:0] bv;
    int          k;
    int          r;

    sif.Start    = 1'b0;
    sif.IR       = 16'h0000;
    sif.Bus      = 16'h0000;
    sif.BusValid = 1'b0;
    Reset        = 1'b1;
    repeat (3) tick();
    check_output("rst_busy", 32'(sif.Busy), 32'd0);
    check_output("rst_done", 32'(sif.Done), 32'd0);
    check_output("rst_ldcc", 32'(sif.LD_CC), 32'd0);
    check_output("rst_nzp", 32'(sif.NZP), 32'd0);
    check_output("rst_ben", 32'(sif.BEN), 32'd0);
    check_output("rst_take", 32'(sif.Take_Branch), 32'd0);
    check_output("rst_timeout", 32'(sif.Timeout), 32'd0);
    Reset = 1'b0;
    tick();

    apply_stimulus(16'h0E05, 16'h0000, 0, 1'b0);
    apply_stimulus(16'h1261, 16'h8000, 0, 1'b0);
    apply_stimulus(16'h0803, 16'h0000, 0, 1'b0);
    apply_stimulus(16'h6281, 16'h0000, 4, 1'b0);
    apply_stimulus(16'h0201, 16'h0000, 0, 1'b0);
    apply_stimulus(16'h0401, 16'h0000, 0, 1'b0);
    apply_stimulus(16'h2005, 16'h1234, 1000, 1'b0);
    apply_stimulus(16'h2005, 16'h7FFF, TO - 1, 1'b0);
    apply_stimulus(16'hE005, 16'h0001, 0, 1'b1);
    apply_stimulus(16'h3005, 16'h0001, 0, 1'b1);
    hold_start_through_done();

    for (int i = 0; i < 80; i++) begin
      ir = 16'($urandom);
      r  = int'($urandom_range(0, 2));
      if (r == 0)      bv = 16'h0000;
      else if (r == 1) bv = {1'b1, 15'($urandom)};
      else             bv = {1'b0, 15'($urandom_range(1, 32767))};
      r = int'($urandom_range(0, 9));
      if (r < 7)       k = int'($urandom_range(0, 5));
      else if (r == 7) k = TO - 1;
      else if (r == 8) k = TO;
      else             k = 200;
      apply_stimulus(ir, bv, k, 1'($urandom_range(0, 1)) & !writes_cc(ir[15:12]));
    end

    reset_mid_wait();
    apply_stimulus(16'h0E05, 16'h0000, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
